// File: rtl/pistorm_arb_pkg.sv
// Shared encodings and defaults for the 68000 bus arbiter.
// Pure declarations; no logic, no latency, no flow control.
// Holds the state codes, counter widths and default timing limits.
package pistorm_arb_pkg;

    localparam int ARB_STATE_W       = 3;
    localparam int ARB_CNT_W         = 8;
    localparam int GRANT_TIMEOUT_DEF = 16;
    localparam int RECLAIM_GAP_DEF   = 2;

    typedef enum logic [ARB_STATE_W-1:0] {
        ST_OWN     = 3'd0,
        ST_PEND    = 3'd1,
        ST_GRANT   = 3'd2,
        ST_EXT     = 3'd3,
        ST_RECLAIM = 3'd4
    } arb_state_t;

endpackage

// File: rtl/pistorm_sync2.sv
// Two-flop synchroniser for an asynchronous active-low pin; resets to idle-high.
// Latency: 2 clk cycles from pin to q; q_pre is the first stage, one cycle ahead of q.
// No backpressure: samples every cycle.
module pistorm_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic q_pre
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

    assign q_pre = meta;

endmodule

// File: rtl/m68k_bus_arbiter.sv
// 68000 bus-request arbiter: hands the bus to an external master via BR/BG/BGACK.
// Latency: 2 c200m sync + 1 registered state cycle; all outputs registered.
// Engine backpressure via eng_hold; external master gated by bg_n/bus_drive_en.
module m68k_bus_arbiter
    import pistorm_arb_pkg::*;
#(
    parameter int GRANT_TIMEOUT = GRANT_TIMEOUT_DEF,
    parameter int RECLAIM_GAP   = RECLAIM_GAP_DEF
) (
    input  logic                   c200m,
    input  logic                   rst_n,
    input  logic                   c7m_rising,
    input  logic                   c7m_falling,
    input  logic                   br_n_raw,
    input  logic                   bgack_n_raw,
    input  logic                   eng_active,
    input  logic                   eng_as_n,
    output logic                   eng_hold,
    output logic                   bus_drive_en,
    output logic                   bg_n,
    output logic [ARB_STATE_W-1:0] arb_state,
    output logic [7:0]             grant_count,
    output logic                   timeout_evt
);

    localparam logic [ARB_CNT_W-1:0] TO_LIM  = ARB_CNT_W'(GRANT_TIMEOUT);
    localparam logic [ARB_CNT_W-1:0] GAP_LIM = ARB_CNT_W'(RECLAIM_GAP);

    arb_state_t           state;
    arb_state_t           nxt;
    logic [ARB_CNT_W-1:0] to_cnt;
    logic [ARB_CNT_W-1:0] gap_cnt;
    logic                 br_s;
    logic                 bgack_s;
    logic                 bgack_pre;
    logic                 br_pre_unused;
    logic                 to_expire;

    pistorm_sync2 u_br_sync (
        .clk   (c200m),
        .rst_n (rst_n),
        .d     (br_n_raw),
        .q     (br_s),
        .q_pre (br_pre_unused)
    );

    pistorm_sync2 u_bgack_sync (
        .clk   (c200m),
        .rst_n (rst_n),
        .d     (bgack_n_raw),
        .q     (bgack_s),
        .q_pre (bgack_pre)
    );

    assign to_expire = (state == ST_GRANT) && bgack_s && !br_s && (to_cnt == TO_LIM);

    always_comb begin
        nxt = ST_RECLAIM;
        case (state)
            ST_OWN:     nxt = br_s ? ST_OWN : ST_PEND;
            ST_PEND: begin
                if (br_s)
                    nxt = ST_OWN;
                else if (!eng_active && eng_as_n && c7m_falling)
                    nxt = ST_GRANT;
                else
                    nxt = ST_PEND;
            end
            ST_GRANT: begin
                if (!bgack_s)
                    nxt = ST_EXT;
                else if (br_s || to_cnt == TO_LIM)
                    nxt = ST_OWN;
                else
                    nxt = ST_GRANT;
            end
            ST_EXT:     nxt = bgack_s ? ST_RECLAIM : ST_EXT;
            ST_RECLAIM: begin
                if (bgack_s && gap_cnt == GAP_LIM)
                    nxt = br_s ? ST_OWN : ST_PEND;
                else
                    nxt = ST_RECLAIM;
            end
            default:    nxt = ST_RECLAIM;
        endcase
    end

    always_ff @(posedge c200m) begin
        if (!rst_n) begin
            state        <= ST_RECLAIM;
            to_cnt       <= '0;
            gap_cnt      <= '0;
            grant_count  <= '0;
            bg_n         <= 1'b1;
            bus_drive_en <= 1'b0;
            eng_hold     <= 1'b1;
            timeout_evt  <= 1'b0;
        end else begin
            state       <= nxt;
            timeout_evt <= to_expire;

            if (state == ST_GRANT && nxt == ST_EXT)
                grant_count <= grant_count + 8'd1;

            if (nxt == ST_GRANT && state != ST_GRANT)
                to_cnt <= '0;
            else if (state == ST_GRANT && c7m_rising)
                to_cnt <= to_cnt + 1'b1;

            // Any BGACK reassertion during the gap means the external master is back.
            if (nxt == ST_RECLAIM && state != ST_RECLAIM)
                gap_cnt <= '0;
            else if (state == ST_RECLAIM) begin
                if (!bgack_s)
                    gap_cnt <= '0;
                else if (c7m_falling && gap_cnt != GAP_LIM)
                    gap_cnt <= gap_cnt + 1'b1;
            end

            bg_n     <= (nxt != ST_GRANT);
            eng_hold <= (nxt != ST_OWN);
            // Gate on the first sync stage so drive drops in the same cycle bgack_s falls.
            bus_drive_en <= (nxt == ST_OWN || nxt == ST_PEND || nxt == ST_GRANT) && bgack_pre;
        end
    end

    assign arb_state = state;

endmodule
